uart_cmd_tx: RTL and testbench

//  Transmit side of the sensor UART link: takes a command word from the register

---
 rtl/uart_cmd_tx.sv | 83 ++++++++
 tb/tb_uart_cmd_tx.sv | 122 ++++++++++++
 2 files changed

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: serialises 1..4 payload bytes of a latched command word as back-to-back 8N1 frames.
module uart_cmd_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        reg_f,
  input  logic [39:0] reg_d,
  output logic        busy,
  output logic        done,
  output logic        drop,
  output logic        tx_pin
);
  localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d, byte_q, byte_d, n_q, n_d;
  logic [31:0] data_q, data_d;
  logic done_q, done_d, drop_q, drop_d;
  logic tick, ok;
  assign tick = baud_q == BW'(BAUD_DIV - 1);
  assign ok = reg_d[39:32] >= 8'd1 && reg_d[39:32] <= 8'd4;
  always_comb begin
    state_d = state_q;
    baud_d = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    byte_d = byte_q;
    n_d = n_q;
    data_d = data_q;
    done_d = 1'b0;
    drop_d = reg_f && (state_q != IDLE || !ok);
    unique case (state_q)
      IDLE: if (reg_f && ok) begin
        state_d = START;
        data_d = reg_d[31:0];
        n_d = reg_d[34:32];
        byte_d = '0;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (tick) begin
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (tick) begin
        done_d = byte_q == n_q - 3'd1;
        state_d = done_d ? IDLE : START;
        byte_d = done_d ? byte_q : byte_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      n_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      n_q <= n_d;
      data_q <= data_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign drop = drop_q;
  assign tx_pin = (state_q == START) ? 1'b0 : (state_q == DATA) ? data_q[{byte_q[1:0], bit_q}] : 1'b1;
endmodule

// File: tb/tb_uart_cmd_tx.sv
// tb_uart_cmd_tx: directed vectors for the command UART transmitter at BAUD_DIV=10.
module tb_uart_cmd_tx;
  logic clk = 1'b0;
  logic rst, reg_f, busy, done, drop, tx_pin;
  logic [39:0] reg_d;
  int checks = 0;
  int errors = 0;

  uart_cmd_tx #(.CLK_FREQ(1_000_000), .UART_BPS(100_000)) dut (
    .sys_clk(clk), .sys_rst(rst), .reg_f(reg_f), .reg_d(reg_d),
    .busy(busy), .done(done), .drop(drop), .tx_pin(tx_pin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] cmd;
    logic [31:0] exp_bytes;
    int n;
    bit exp_drop;
  } vec_t;
  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic send(input logic [39:0] d);
    reg_f = 1'b1;
    reg_d = d;
    step();
    reg_f = 1'b0;
    reg_d = ~d;
  endtask

  // expects to be called on the cycle after acceptance; returns on the done cycle
  task automatic check_stream(input logic [31:0] exp_bytes, input int n, input int strobe_at);
    logic [7:0] b;
    logic e;
    int p;
    for (int c = 0; c < n * 100; c++) begin
      b = exp_bytes[31 - 8 * (c / 100) -: 8];
      p = (c % 100) / 10;
      e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p - 1];
      chk("tx_bit", tx_pin, e);
      chk("busy_hi", busy, 1'b1);
      chk("done_lo", done, 1'b0);
      chk("drop_mid", drop, c == strobe_at + 1);
      reg_f = c == strobe_at;
      if (c == strobe_at) reg_d = 40'h01_0000_00FF;
      step();
    end
    reg_f = 1'b0;
    chk("busy_fall", busy, 1'b0);
    chk("done_pulse", done, 1'b1);
    chk("tx_idle", tx_pin, 1'b1);
  endtask

  initial begin
    vecs[0] = '{40'h01_0000_00A5, 32'hA500_0000, 1, 1'b0};
    vecs[1] = '{40'h04_1122_3344, 32'h4433_2211, 4, 1'b0};
    vecs[2] = '{40'h00_1234_5678, 32'h0, 0, 1'b1};
    vecs[3] = '{40'h05_1234_5678, 32'h0, 0, 1'b1};
    vecs[4] = '{40'h02_0000_BEEF, 32'hEFBE_0000, 2, 1'b0};
    vecs[5] = '{40'hFF_FFFF_FFFF, 32'h0, 0, 1'b1};
    vecs[6] = '{40'h03_00C3_5A01, 32'h015A_C300, 3, 1'b0};
    vecs[7] = '{40'h01_0000_0000, 32'h0000_0000, 1, 1'b0};
    rst = 1'b1;
    reg_f = 1'b0;
    reg_d = '0;
    repeat (3) step();
    chk("rst_tx", tx_pin, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_drop", drop, 1'b0);
    rst = 1'b0;
    repeat (2) step();
    chk("idle_tx", tx_pin, 1'b1);
    // each vector is launched in the previous one's done/drop cycle
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].cmd);
      if (vecs[i].exp_drop) begin
        chk("drop_pulse", drop, 1'b1);
        chk("drop_busy", busy, 1'b0);
        chk("drop_tx", tx_pin, 1'b1);
      end else begin
        check_stream(vecs[i].exp_bytes, vecs[i].n, -10);
      end
    end
    step();
    chk("done_once", done, 1'b0);
    chk("drop_clr", drop, 1'b0);
    repeat (3) step();
    send(40'h02_0000_3C96);
    check_stream(32'h963C_0000, 2, 30);
    step();
    send(40'h02_0000_55AA);
    repeat (143) step();
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_tx", tx_pin, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_tx", tx_pin, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (2) step();
    send(40'h01_0000_00C6);
    check_stream(32'hC600_0000, 1, -10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
